rr_arb4_enc: RTL and testbench
==============================

Name: rr_arb4_enc

Overview:
- 4-requester round-robin arbiter. Shares one downstream resource between four clients and holds each grant until the owner finishes.
- Presents the grant both as a one-hot vector and as a 2-bit encoded index, using the same encoding as the team's 4-to-2 encoder: bit0→00, bit1→01, bit2→10, bit3→11.
- Sits between the client request lines and the shared-resource mux select. A hold-time watchdog prevents starvation.

Parameters:
- MAX_HOLD, default 8: maximum cycles a grant may be held before it is forcibly released. Legal range 1..255.
- CNT_W, default 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  per-client request; level, held high while the client wants the resource.
- done  input  1  single-cycle pulse from the current owner: transaction complete. Ignored when no grant is active.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- gnt_idx  output  2  registered encoded index of the owner; 2'b00 when idle.
- gnt_vld  output  1  registered; high while any grant is active.
- timeout  output  1  registered single-cycle pulse: grant revoked by the watchdog.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0
  - state=IDLE, ptr=0, hold_cnt=0
- Reset applied mid-grant takes effect at the same edge. It overrides done and the watchdog. No timeout pulse is produced.
- ptr is a 2-bit priority pointer holding the index of the highest-priority client.
- IDLE state:
  - If req≠0, select the first set bit of req, searching ptr, ptr+1, ... with wrap mod 4.
  - On the next edge: gnt=onehot(sel), gnt_idx=sel, gnt_vld=1, hold_cnt=1, state→BUSY.
  - Latency: req sampled high at edge N gives gnt visible after edge N, i.e. 1 cycle.
  - If req=0, stay in IDLE with outputs at their idle values.
- BUSY state: the grant is held stable. On each edge, evaluate in priority order:
  1. done=1: release.
  2. req[gnt_idx]=0 (owner withdrew): release.
  3. hold_cnt==MAX_HOLD: release with timeout=1 for one cycle.
  4. Otherwise: hold_cnt+1.
- Release (same edge):
  - gnt=0, gnt_idx=0, gnt_vld=0, hold_cnt=0
  - ptr=(owner+1) mod 4
  - state→IDLE
- After release there is exactly one dead cycle with gnt_vld=0 (bus turnaround). Re-arbitration happens at the following edge using the updated ptr. Minimum spacing between grants is therefore 1 idle cycle.
- done coinciding with watchdog expiry: treated as a normal release; timeout stays 0.
- Changes on non-owner req bits while BUSY have no effect until the next IDLE evaluation.
- timeout is high for exactly the cycle following the expiry edge, then returns to 0.
- Invariants (checked every cycle):
  - gnt == (gnt_vld ? onehot(gnt_idx) : 4'b0000)
  - gnt is never multi-hot.
  - gnt_vld=1 implies 1 ≤ hold_cnt ≤ MAX_HOLD.
- No combinational path from any input to any output.

Test Plan:
- Reset then single request: rst 2 cycles, req=4'b0100 → one cycle later gnt=4'b0100, gnt_idx=2'b10, gnt_vld=1; done pulse → next cycle gnt=0, gnt_vld=0.
- Fairness with all requesting: req=4'b1111 held, done pulsed 2 cycles after each grant → gnt_idx sequence 0,1,2,3,0, with one idle cycle between grants.
- Pointer wrap: after client 3 is served, ptr=0; req=4'b1001 → next grant is idx 0; after its done, grant goes to idx 3.
- Watchdog: MAX_HOLD=8, req=4'b0010 held, no done → gnt_vld high exactly 8 cycles, timeout=1 for one cycle at release, then client 1 re-granted after 1 idle cycle (sole requester).
- Simultaneous done and expiry: done asserted on the 8th hold cycle → release with timeout=0; owner drops req mid-grant → release on next edge, ptr advances.
- Reset mid-grant: rst during BUSY with idx 2 → next cycle all outputs 0 and ptr=0; req=4'b1111 → grant idx 0.

Source files
------------

// File: rtl/rr_arb4_enc_if.sv
// Request/grant bundle between the four clients and the round-robin arbiter.
// The master side is the client group; the slave side is the arbiter.
interface rr_arb4_enc_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_arb4_enc.sv
// Four-client round-robin arbiter with grant hold, hold-time watchdog and a
// registered one-hot plus encoded grant.
module rr_arb4_enc #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb4_enc_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             timeout_q, timeout_d;

    logic       found;
    logic [1:0] sel;
    logic [1:0] cand;
    logic       expired;
    logic       owner_req;

    // Walk from the largest offset down so the client nearest ptr wins last.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign expired   = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign owner_req = bus.req[gnt_idx_q];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BUSY;
                    gnt_d      = 4'b0001 << sel;
                    gnt_idx_d  = sel;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            BUSY: begin
                if (bus.done || !owner_req || expired) begin
                    state_d    = IDLE;
                    ptr_d      = gnt_idx_q + 2'd1;
                    gnt_d      = 4'b0000;
                    gnt_idx_d  = 2'b00;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                    // Only a pure watchdog expiry is flagged; done or withdrawal wins.
                    timeout_d  = !bus.done && owner_req && expired;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            gnt_q      <= 4'b0000;
            gnt_idx_q  <= 2'b00;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Directed bench for rr_arb4_enc: a vector table for arbitration order and
// release causes, plus hand-written watchdog sequences.
module tb_rr_arb4_enc;

    logic clk;
    logic rst;
    rr_arb4_enc_if bus ();

    rr_arb4_enc #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] g, input logic [1:0] ix,
                       input logic v, input logic t);
        vec_t e;
        e.rst = r; e.req = rq; e.done = d;
        e.gnt = g; e.idx = ix; e.vld = v; e.to = t;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {gnt,idx,vld,to}=%b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout};
    endfunction

    function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] ix,
                                      input logic v, input logic t);
        return {g, ix, v, t};
    endfunction

    // Advance one edge, sample 1 time unit later, and check the grant encoding invariant.
    task automatic tick();
        logic [3:0] want;
        @(posedge clk);
        #1;
        want = bus.gnt_vld ? (4'b0001 << bus.gnt_idx) : 4'b0000;
        check("invariant", {bus.gnt, 4'b0000}, {want, 4'b0000});
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic d);
        rst = r; bus.req = rq; bus.done = d;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        drive(1'b1, 4'b0000, 1'b0);

        // rst req done | gnt idx vld to  (outputs after the edge sampling the inputs)
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);  // single request, 1-cycle latency
        add(0, 4'b0100, 1, 4'b0000, 2'd0, 0, 0);  // done releases
        add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);  // reset ptr to 0
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);  // fairness: 0
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);  // 1
        add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);  // 2
        add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);  // 3
        add(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);  // ptr wraps to 0
        add(0, 4'b1001, 0, 4'b0001, 2'd0, 1, 0);  // wrap: 0 first
        add(0, 4'b1001, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0);  // then 3
        add(0, 4'b1001, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0);  // non-owner req ignored
        add(0, 4'b0001, 0, 4'b0000, 2'd0, 0, 0);  // owner withdrew, ptr=2
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);  // search 2,3,0
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);  // done ignored when idle
        add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b0100, 0, 4'b0000, 2'd0, 0, 0);  // reset mid-grant
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);  // ptr back at 0
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].done);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  pk(vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].to));
        end

        // Watchdog: sole requester holds for MAX_HOLD cycles, then is revoked.
        drive(0, 4'b0010, 0);
        tick();
        check("wd_grant", outs(), pk(4'b0010, 2'd1, 1, 0));
        for (int k = 2; k <= 8; k++) begin
            tick();
            check($sformatf("wd_hold%0d", k), outs(), pk(4'b0010, 2'd1, 1, 0));
        end
        tick();
        check("wd_expire", outs(), pk(4'b0000, 2'd0, 0, 1));
        tick();
        check("wd_regrant", outs(), pk(4'b0010, 2'd1, 1, 0));

        // done on the 8th hold cycle: normal release, no timeout pulse.
        for (int k = 2; k <= 8; k++) begin
            tick();
            check($sformatf("dx_hold%0d", k), outs(), pk(4'b0010, 2'd1, 1, 0));
        end
        drive(0, 4'b0010, 1);
        tick();
        check("dx_release", outs(), pk(4'b0000, 2'd0, 0, 0));
        drive(0, 4'b1111, 0);
        tick();
        check("dx_ptr_adv", outs(), pk(4'b0100, 2'd2, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
